// File: rtl/fp_accum_array.sv
// fp_accum_array
// Purpose:
//   NUM_CH-lane floating-point accumulator for FloPoCo-format words. Sits
//   between the MAC/product stage and the adapter output buffer. A start
//   pulse latches a beat count. Each lane then sums that many input beats,
//   and the result is held until the consumer takes it.
//
// FloPoCo word layout (BW+1 = 18 bits):
//   [17:16] exception: 00 zero, 01 normal, 10 infinity, 11 NaN
//   [15]    sign
//   [14:10] exponent (bias 15)
//   [9:0]   fraction
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous abort. Forces IDLE and zeroes all lane sums.
//   start        begins a run. Sampled in IDLE, or in DONE together with
//                the output handshake.
//   cfg_len      number of beats to accumulate, latched on start (0 means 1)
//   in_valid     input beat valid
//   in_ready     input beat ready
//   in_data      lane c is at [c*(BW+1) +: BW+1]
//   in_mask      per-lane add enable for the current beat
//   bias_data    initial lane sums (present only with FP_ACCUM_BIAS_EN)
//   out_valid    output result valid
//   out_ready    output result ready
//   out_data     lane sums, packed the same way as in_data
//   beat_cnt     number of beats accepted in the current run
//   busy         high in ACC or DONE
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid and ready are both high.
//   in_ready is high only in ACC. out_valid is high only in DONE. While
//   out_valid is high, out_data and beat_cnt do not change.
//
// Configuration macro:
//   FP_ACCUM_BIAS_EN adds the bias_data port and a one-cycle LOAD state.
//   In LOAD the lane sums are preloaded from bias_data.
module fp_accum_array #(
    parameter int BITWIDTH = 16,
    parameter int BW       = BITWIDTH + 2 - 1,
    parameter int NUM_CH   = 4,
    parameter int LEN_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*(BW+1)-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_mask,
`ifdef FP_ACCUM_BIAS_EN
    input  logic [NUM_CH*(BW+1)-1:0] bias_data,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*(BW+1)-1:0] out_data,
    output logic [LEN_W-1:0]         beat_cnt,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2,
        S_LOAD = 2'd3
    } state_t;

`ifdef FP_ACCUM_BIAS_EN
    localparam state_t START_ST = S_LOAD;
`else
    localparam state_t START_ST = S_ACC;
`endif

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [BW:0]      sum_q [NUM_CH];
    logic [BW:0]      add_r [NUM_CH];

    logic acc_fire;
    logic last_beat;
    logic restart;

    assign acc_fire  = (state_q == S_ACC) && in_valid;
    assign last_beat = acc_fire && (beat_cnt == len_q - 1'b1);
    // A start is honoured from IDLE, or from DONE only when the result is
    // consumed on the same cycle (back-to-back run with no IDLE gap).
    assign restart   = start && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && out_ready));

    // One combinational adder per lane: X = incoming beat, Y = running sum.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        FPADD_16bit_WRAPPER u_add (
            .X (in_data[c*(BW+1) +: BW+1]),
            .Y (sum_q[c]),
            .R (add_r[c])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = START_ST;
            S_ACC:  if (last_beat) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = start ? START_ST : S_IDLE;
`ifdef FP_ACCUM_BIAS_EN
            S_LOAD: state_d = S_ACC;
`endif
            default: state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_ACC);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ACC) || (state_q == S_DONE);
    end

    // Datapath: length latch, beat counter, lane sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= {{(LEN_W-1){1'b0}}, 1'b1};
            beat_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
        end else if (restart) begin
            len_q    <= (cfg_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : cfg_len;
            beat_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
`ifdef FP_ACCUM_BIAS_EN
        end else if (state_q == S_LOAD) begin
            for (int c = 0; c < NUM_CH; c++) sum_q[c] <= bias_data[c*(BW+1) +: BW+1];
`endif
        end else if (acc_fire) begin
            // A masked lane holds its sum, but the beat still counts.
            beat_cnt <= beat_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_mask[c]) sum_q[c] <= add_r[c];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < NUM_CH; c++) out_data[c*(BW+1) +: BW+1] = sum_q[c];
    end

endmodule

// FPADD_16bit_WRAPPER
// Combinational FloPoCo adder (wE=5, wF=10), round to nearest even.
// Subnormals are not representable, so underflow flushes to +0 and
// exponent overflow goes to infinity. A NaN or infinity operand passes
// through bit-for-bit.
// Ports: X, Y operands; R sum.
module FPADD_16bit_WRAPPER (
    input  logic [17:0] X,
    input  logic [17:0] Y,
    output logic [17:0] R
);
    logic [15:0]       a, b;
    logic [4:0]        d;
    logic [13:0]       ma, mb, mb_sh, norm;
    logic              sticky, sub, rnd_up, found;
    logic [14:0]       sum;
    logic [3:0]        lz;
    logic signed [7:0] e;
    logic [11:0]       mant_r;

    always_comb begin
        a = X[15:0]; b = Y[15:0]; d = '0; ma = '0; mb = '0; mb_sh = '0;
        norm = '0; sticky = 1'b0; sub = 1'b0; rnd_up = 1'b0; found = 1'b0;
        sum = '0; lz = '0; e = '0; mant_r = '0;
        R = '0;
        if (X[17:16] == 2'b11)      R = X;
        else if (Y[17:16] == 2'b11) R = Y;
        else if (X[17:16] == 2'b10 && Y[17:16] == 2'b10)
            R = (X[15] == Y[15]) ? X : {2'b11, 16'd0};
        else if (X[17:16] == 2'b10) R = X;
        else if (Y[17:16] == 2'b10) R = Y;
        else if (X[17:16] == 2'b00) R = Y;
        else if (Y[17:16] == 2'b00) R = X;
        else begin
            // Operand a is the one with the larger magnitude, so a - b never goes negative.
            if (X[14:0] < Y[14:0]) begin
                a = Y[15:0];
                b = X[15:0];
            end
            d  = a[14:10] - b[14:10];
            ma = {1'b1, a[9:0], 3'b000};
            mb = {1'b1, b[9:0], 3'b000};
            if (d > 5'd13) begin
                mb_sh  = '0;
                sticky = 1'b1;
            end else begin
                mb_sh  = mb >> d;
                sticky = |(mb & ((14'd1 << d) - 14'd1));
            end
            mb_sh[0] = mb_sh[0] | sticky;
            sub = a[15] ^ b[15];
            sum = sub ? ({1'b0, ma} - {1'b0, mb_sh}) : ({1'b0, ma} + {1'b0, mb_sh});
            e   = {3'b000, a[14:10]};
            if (sum[14]) begin
                norm = {sum[14:2], sum[1] | sum[0]};
                e    = e + 8'sd1;
            end else begin
                for (int i = 13; i >= 0; i--) begin
                    if (!found && sum[i]) begin
                        lz    = 4'(13 - i);
                        found = 1'b1;
                    end
                end
                norm = sum[13:0] << lz;
                e    = e - $signed({4'b0000, lz});
            end
            rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
            mant_r = {1'b0, norm[13:3]} + {11'd0, rnd_up};
            if (mant_r[11]) e = e + 8'sd1;
            if (sum == 15'd0)    R = '0;
            else if (e > 8'sd31) R = {2'b10, a[15], 15'd0};
            else if (e < 8'sd0)  R = '0;
            else R = {2'b01, a[15], e[4:0], mant_r[11] ? mant_r[10:1] : mant_r[9:0]};
        end
    end
endmodule

// File: tb/tb_fp_accum_array.sv
`timescale 1ns/1ps
module tb_fp_accum_array;
    localparam int BW     = 17;
    localparam int NUM_CH = 4;
    localparam int LEN_W  = 8;
    localparam int DW     = NUM_CH * (BW + 1);
`ifdef FP_ACCUM_BIAS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // FloPoCo encodings: {exc[1:0], sign, exp[4:0] (bias 15), frac[9:0]}
    localparam logic [BW:0] FP_ZERO    = 18'h00000;
    localparam logic [BW:0] FP_HALF    = 18'h13800;
    localparam logic [BW:0] FP_ONE     = 18'h13C00;
    localparam logic [BW:0] FP_NEG_ONE = 18'h1BC00;
    localparam logic [BW:0] FP_TWO     = 18'h14000;
    localparam logic [BW:0] FP_TWO_5   = 18'h14100;
    localparam logic [BW:0] FP_THREE   = 18'h14200;
    localparam logic [BW:0] FP_FOUR    = 18'h14400;
    localparam logic [BW:0] FP_PINF    = 18'h20000;
    localparam logic [BW:0] FP_NAN     = 18'h30000;

    logic             clk, rst, clear, start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid, in_ready;
    logic [DW-1:0]    in_data;
    logic [NUM_CH-1:0] in_mask;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [LEN_W-1:0] beat_cnt;
    logic             busy;
`ifdef FP_ACCUM_BIAS_EN
    logic [DW-1:0]    bias_data;
`endif

    fp_accum_array dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
`ifdef FP_ACCUM_BIAS_EN
        .bias_data (bias_data),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input logic [BW:0] l3, input logic [BW:0] l2,
                                            input logic [BW:0] l1, input logic [BW:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        int n;
        cfg_len = len;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        checkn("start_to_ready", n, LAT);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [NUM_CH-1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag);
        logic [DW-1:0] expv;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check1({tag, "_out_valid"}, out_valid, 1'b1);
        checkd({tag, "_out_data"}, out_data, expv);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check1({tag, "_out_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clear = 1'b0; start = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
`ifdef FP_ACCUM_BIAS_EN
        bias_data = '0;
`endif
        // Reset state
        tick(); tick();
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        checkn("rst_beat_cnt", int'(beat_cnt), 0);
        checkd("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        // Stream: cfg_len=3, all lanes 1.0, in_valid held high
        exp_q.push_back(pack4(FP_THREE, FP_THREE, FP_THREE, FP_THREE));
        do_start(8'd3);
        in_data  = pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE);
        in_mask  = 4'hF;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 10);
        in_valid = 1'b0;
        checkn("stream_latency", n, 3);
        checkn("stream_beat_cnt", int'(beat_cnt), 3);
        check1("stream_in_ready_low", in_ready, 1'b0);
        check1("stream_busy", busy, 1'b1);
        take_result("stream");
        check1("stream_idle_busy", busy, 1'b0);
        checkd("stream_sum_kept", out_data, pack4(FP_THREE, FP_THREE, FP_THREE, FP_THREE));

        // Mask and backpressure: cfg_len=4, mask 0101 on beats 2 and 3
        exp_q.push_back(pack4(FP_TWO, FP_FOUR, FP_TWO, FP_FOUR));
        do_start(8'd4);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        // idle gap with a stray start, which ACC must ignore
        cfg_len = 8'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        checkn("acc_start_ignored_cnt", int'(beat_cnt), 1);
        check1("acc_start_ignored_rdy", in_ready, 1'b1);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'b0101);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'b0101);
        checkn("mask_cnt3", int'(beat_cnt), 3);
        check1("mask_not_done", out_valid, 1'b0);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        check1("mask_done", out_valid, 1'b1);
        checkn("mask_cnt4", int'(beat_cnt), 4);
        // stall 5 cycles: data arrives but must not be taken, start ignored
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            checkd("stall_out_data", out_data, exp_q[0]);
            check1("stall_out_valid", out_valid, 1'b1);
            checkn("stall_beat_cnt", int'(beat_cnt), 4);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkd("mask_result", out_data, exp_q.pop_front());

        // Back-to-back: handshake plus start in DONE
        exp_q.push_back(pack4(FP_ONE, FP_TWO, FP_TWO_5, FP_TWO));
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = 8'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check1("b2b_out_valid", out_valid, 1'b0);
        checkn("b2b_beat_cnt", int'(beat_cnt), 0);
        checkd("b2b_sums_zero", out_data, '0);
        check1("b2b_busy", busy, LAT == 1);
        repeat (LAT - 1) tick();
        check1("b2b_ready", in_ready, 1'b1);
        beat(pack4(FP_HALF, FP_THREE, FP_TWO, FP_ONE), 4'hF);
        beat(pack4(FP_HALF, FP_NEG_ONE, FP_HALF, FP_ONE), 4'hF);
        take_result("b2b");

        // Clear after 2 of 5 beats
        do_start(8'd5);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        checkn("clear_pre_cnt", int'(beat_cnt), 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check1("clear_in_ready", in_ready, 1'b0);
        check1("clear_busy", busy, 1'b0);
        check1("clear_out_valid", out_valid, 1'b0);
        checkn("clear_beat_cnt", int'(beat_cnt), 0);
        checkd("clear_sums", out_data, '0);

        // Zero length is treated as one beat
        exp_q.push_back(pack4(FP_TWO_5, FP_TWO_5, FP_TWO_5, FP_TWO_5));
        do_start(8'd0);
        beat(pack4(FP_TWO_5, FP_TWO_5, FP_TWO_5, FP_TWO_5), 4'hF);
        checkn("len0_beat_cnt", int'(beat_cnt), 1);
        take_result("len0");

        // Exception encodings pass through the adders
        exp_q.push_back(pack4(FP_TWO, FP_PINF, FP_PINF, FP_NAN));
        do_start(8'd2);
        beat(pack4(FP_ONE, FP_ONE, FP_PINF, FP_NAN), 4'hF);
        beat(pack4(FP_ONE, FP_PINF, FP_ONE, FP_ONE), 4'hF);
        take_result("exc");

        // Async reset mid-ACC
        do_start(8'd3);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        in_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check1("arst_in_ready", in_ready, 1'b0);
        check1("arst_out_valid", out_valid, 1'b0);
        check1("arst_busy", busy, 1'b0);
        checkn("arst_beat_cnt", int'(beat_cnt), 0);
        checkd("arst_sums", out_data, '0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef FP_ACCUM_BIAS_EN
        // Bias preload: 0.5 + 1.0 + 1.0
        bias_data = pack4(FP_HALF, FP_HALF, FP_HALF, FP_HALF);
        exp_q.push_back(pack4(FP_TWO_5, FP_TWO_5, FP_TWO_5, FP_TWO_5));
        cfg_len = 8'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check1("bias_load_not_ready", in_ready, 1'b0);
        tick();
        check1("bias_ready_after_2", in_ready, 1'b1);
        checkd("bias_preloaded", out_data, pack4(FP_HALF, FP_HALF, FP_HALF, FP_HALF));
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        beat(pack4(FP_ONE, FP_ONE, FP_ONE, FP_ONE), 4'hF);
        take_result("bias");
        bias_data = '0;
`endif

        checkn("exp_q_drained", exp_q.size(), 0);
        checkd("final_zero_const", pack4(FP_ZERO, FP_ZERO, FP_ZERO, FP_ZERO) | out_data, out_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
